// File: rtl/path_delay_meter.sv
// path_delay_meter: watches the four inputs and the single output of a path
// network. It timestamps an input transition, counts edges until the output
// responds, and reports the latency, the source pin and a limit check.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | waiting for an input change; flags spurious output toggles
//   S_MEASURE | counting edges since the start edge until out_obs changes
module path_delay_meter #(
  parameter int CNT_W    = 8,
  parameter int LIMIT_AB = 9,
  parameter int LIMIT_CD = 11,
  parameter int TIMEOUT  = 63
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             out_obs,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] lat,
  output logic [1:0]       src,
  output logic             viol,
  output logic             overlap,
  output logic             tmo,
  output logic             spurious
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LIM_AB_C = CNT_W'(LIMIT_AB);
  localparam logic [CNT_W-1:0] LIM_CD_C = CNT_W'(LIMIT_CD);
  localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       prev_in_q;
  logic             prev_out_q;
  logic [1:0]       src_r_q, src_r_d;
  logic             ovl_r_q, ovl_r_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [1:0]       src_q, src_d;
  logic             viol_q, viol_d;
  logic             overlap_q, overlap_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             spurious_q, spurious_d;

  logic [3:0]       pins;
  logic [3:0]       chg;
  logic             in_chg;
  logic             out_chg;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] lim;
  logic [1:0]       first_src;

  // Change detection against last edge's samples; pin a sits in bit 3.
  always_comb begin
    pins    = {a, b, c, d};
    chg     = pins ^ prev_in_q;
    in_chg  = |chg;
    out_chg = out_obs ^ prev_out_q;
    // cnt stays below TIMEOUT in MEASURE, so the increment cannot wrap.
    cnt_inc = cnt_q + 1'b1;
    lim     = src_r_q[1] ? LIM_CD_C : LIM_AB_C;
    if (chg[3])      first_src = 2'd0;
    else if (chg[2]) first_src = 2'd1;
    else if (chg[1]) first_src = 2'd2;
    else             first_src = 2'd3;
  end

  // Next-state and result computation for the IDLE/MEASURE controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_r_d    = src_r_q;
    ovl_r_d    = ovl_r_q;
    lat_d      = lat_q;
    src_d      = src_q;
    viol_d     = viol_q;
    overlap_d  = overlap_q;
    valid_d    = 1'b0;
    tmo_d      = 1'b0;
    spurious_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An output change on the same edge as an input change is ignored.
        if (enable && in_chg) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
          src_r_d = first_src;
          ovl_r_d = 1'b0;
        end else if (enable && out_chg) begin
          spurious_d = 1'b1;
        end
      end
      S_MEASURE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (out_chg) begin
          lat_d     = cnt_inc;
          src_d     = src_r_q;
          viol_d    = (cnt_inc > lim);
          overlap_d = ovl_r_q | in_chg;
          valid_d   = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_inc == TMO_C) begin
          lat_d   = TMO_C;
          src_d   = src_r_q;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (in_chg) ovl_r_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; pin history reloads even in reset so that
  // releasing reset never produces a phantom change.
  always_ff @(posedge clock) begin
    prev_in_q  <= pins;
    prev_out_q <= out_obs;
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      src_r_q    <= '0;
      ovl_r_q    <= 1'b0;
      lat_q      <= '0;
      src_q      <= '0;
      viol_q     <= 1'b0;
      overlap_q  <= 1'b0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_r_q    <= src_r_d;
      ovl_r_q    <= ovl_r_d;
      lat_q      <= lat_d;
      src_q      <= src_d;
      viol_q     <= viol_d;
      overlap_q  <= overlap_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
      spurious_q <= spurious_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy     = (state_q == S_MEASURE);
    valid    = valid_q;
    lat      = lat_q;
    src      = src_q;
    viol     = viol_q;
    overlap  = overlap_q;
    tmo      = tmo_q;
    spurious = spurious_q;
  end

endmodule
